// File: rtl/matrix_scan_ctrl_if.sv
// Frame-buffer, swap handshake and LED-matrix driver signals of the scan controller.
// The master side is the controller; the slave side is the frame buffer and matrix.
interface matrix_scan_ctrl_if;
  logic        enable;
  logic [3:0]  row_addr;
  logic [15:0] row_data;
  logic        swap_req;
  logic        swap_ack;
  logic        frame_done;
  logic        CSDI;
  logic        CCLK;
  logic        RSDI;
  logic        RCLK;
  logic        LE;
  logic        OEB;

  modport master (
    input  enable, row_data, swap_req,
    output row_addr, swap_ack, frame_done, CSDI, CCLK, RSDI, RCLK, LE, OEB
  );

  modport slave (
    output enable, row_data, swap_req,
    input  row_addr, swap_ack, frame_done, CSDI, CCLK, RSDI, RCLK, LE, OEB
  );
endinterface

// File: rtl/matrix_scan_ctrl.sv
// 16x16 LED matrix row scanner: fetches a row, shifts it into the column register,
// clocks the row register, latches and displays it for 2^SCREENTIMERWIDTH cycles.
module matrix_scan_ctrl #(
  parameter int unsigned SCREENTIMERWIDTH = 10
) (
  input logic                 clk32mhz,
  input logic                 reset,
  matrix_scan_ctrl_if.master  scan_io
);

  typedef enum logic [2:0] {
    StIdle, StBlank, StFetch, StShift, StRowClk, StLatch, StDisplay
  } state_e;

  state_e                        state_q, state_d;
  logic [3:0]                    r_q, r_d;
  logic [4:0]                    cnt_q, cnt_d;
  logic [SCREENTIMERWIDTH-1:0]   tmr_q, tmr_d;
  logic [15:0]                   sreg_q, sreg_d;

  logic [3:0] row_addr_q, row_addr_d;
  logic       frame_done_q, frame_done_d;
  logic       swap_ack_q, swap_ack_d;
  logic       csdi_q, csdi_d;
  logic       cclk_q, cclk_d;
  logic       rsdi_q, rsdi_d;
  logic       rclk_q, rclk_d;
  logic       le_q, le_d;
  logic       oeb_q, oeb_d;

  always_comb begin
    state_d      = state_q;
    r_d          = r_q;
    cnt_d        = cnt_q;
    tmr_d        = tmr_q;
    sreg_d       = sreg_q;
    frame_done_d = 1'b0;
    swap_ack_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (scan_io.enable) begin
          state_d = StBlank;
          r_d     = 4'd0;
        end
      end
      StBlank: state_d = StFetch;
      StFetch: begin
        sreg_d  = scan_io.row_data;
        cnt_d   = 5'd0;
        state_d = StShift;
      end
      StShift: begin
        // cnt[0] is the phase: even drives data, odd raises CCLK then shifts.
        cnt_d = cnt_q + 5'd1;
        if (cnt_q[0]) sreg_d = sreg_q << 1;
        if (cnt_q == 5'd31) begin
          cnt_d   = 5'd0;
          state_d = StRowClk;
        end
      end
      StRowClk: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q[0]) begin
          cnt_d   = 5'd0;
          state_d = StLatch;
        end
      end
      StLatch: begin
        tmr_d   = '0;
        state_d = StDisplay;
      end
      StDisplay: begin
        tmr_d = tmr_q + 1'b1;
        if (&tmr_q) begin
          tmr_d = '0;
          if (r_q == 4'd15) begin
            frame_done_d = 1'b1;
            swap_ack_d   = scan_io.swap_req;
            r_d          = 4'd0;
            state_d      = scan_io.enable ? StBlank : StIdle;
          end else begin
            r_d     = r_q + 4'd1;
            state_d = StBlank;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are decoded from the next state so every pin comes straight from a flop.
    row_addr_d = r_d;
    csdi_d     = (state_d == StShift) && sreg_d[15];
    cclk_d     = (state_d == StShift) && cnt_d[0];
    rsdi_d     = (state_d == StRowClk) && (r_d == 4'd0);
    rclk_d     = (state_d == StRowClk) && cnt_d[0];
    le_d       = (state_d == StLatch);
    oeb_d      = (state_d != StDisplay);
  end

  always_ff @(posedge clk32mhz) begin
    if (reset) begin
      state_q      <= StIdle;
      r_q          <= 4'd0;
      cnt_q        <= 5'd0;
      tmr_q        <= '0;
      sreg_q       <= 16'd0;
      row_addr_q   <= 4'd0;
      frame_done_q <= 1'b0;
      swap_ack_q   <= 1'b0;
      csdi_q       <= 1'b0;
      cclk_q       <= 1'b0;
      rsdi_q       <= 1'b0;
      rclk_q       <= 1'b0;
      le_q         <= 1'b0;
      oeb_q        <= 1'b1;
    end else begin
      state_q      <= state_d;
      r_q          <= r_d;
      cnt_q        <= cnt_d;
      tmr_q        <= tmr_d;
      sreg_q       <= sreg_d;
      row_addr_q   <= row_addr_d;
      frame_done_q <= frame_done_d;
      swap_ack_q   <= swap_ack_d;
      csdi_q       <= csdi_d;
      cclk_q       <= cclk_d;
      rsdi_q       <= rsdi_d;
      rclk_q       <= rclk_d;
      le_q         <= le_d;
      oeb_q        <= oeb_d;
    end
  end

  assign scan_io.row_addr   = row_addr_q;
  assign scan_io.frame_done = frame_done_q;
  assign scan_io.swap_ack   = swap_ack_q;
  assign scan_io.CSDI       = csdi_q;
  assign scan_io.CCLK       = cclk_q;
  assign scan_io.RSDI       = rsdi_q;
  assign scan_io.RCLK       = rclk_q;
  assign scan_io.LE         = le_q;
  assign scan_io.OEB        = oeb_q;

endmodule
